// File: rtl/te_radio_seq.sv
// ---------------------------------------------------------------------------
// te_radio_seq
//
// Multi-channel radio enable sequencer. Each channel synchronises its enable
// and RX-mode request, waits for the shared PLL-settled indication, counts out
// a programmable settle time and only then asserts the qualified radio enable
// to the front end. A mode change while active (RX/TX turnaround) re-runs the
// settle time; waiting too long for the PLL parks the channel in a fault
// state that raises teError until the request is withdrawn.
//
// Configuration macro: TE_INPUT_SYNC_EN
//   defined   : 2-flop synchronisers on the asynchronous request inputs.
//   undefined : requests are treated as synchronous; one register stage.
//
// Parameters:
//   NUM_CH        number of independent channels
//   SIZE_T_ARSTFS width of the settle-time input
//   PLL_TIMEOUT   cycles allowed in WAIT_PLL before fault (< 2^16)
//
// Ports:
//   clk                  sole clock
//   rst                  synchronous active-high reset
//   pllSettled           shared PLL lock indication (synchronous)
//   tArstFs              settle time, sampled when a channel enters SETTLE
//   radioEnableUnsynced  per-channel enable request
//   radioRxEnUnsynced    per-channel mode request (1 = RX, 0 = TX)
//   radioEnableSynced    synchronised enable request
//   radioRxEnSynced      synchronised mode request
//   radioEnable          qualified radio enable
//   radioRxEn            qualified RX enable (implies radioEnable)
//   teError              PLL-wait timeout flag
// ---------------------------------------------------------------------------
module te_radio_seq #(
    parameter int NUM_CH        = 2,
    parameter int SIZE_T_ARSTFS = 8,
    parameter int PLL_TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pllSettled,
    input  logic [SIZE_T_ARSTFS-1:0] tArstFs,
    input  logic [NUM_CH-1:0]        radioEnableUnsynced,
    input  logic [NUM_CH-1:0]        radioRxEnUnsynced,
    output logic [NUM_CH-1:0]        radioEnableSynced,
    output logic [NUM_CH-1:0]        radioRxEnSynced,
    output logic [NUM_CH-1:0]        radioEnable,
    output logic [NUM_CH-1:0]        radioRxEn,
    output logic [NUM_CH-1:0]        teError
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PLL,
        ST_SETTLE,
        ST_ACTIVE,
        ST_FAULT
    } state_e;

    logic [CNT_W-1:0]  settle_load;
    logic [NUM_CH-1:0] en_sync_q;
    logic [NUM_CH-1:0] rx_sync_q;

    assign settle_load = CNT_W'(tArstFs);

    // ------------------------------------------------------------------
    // Request input stage
    // ------------------------------------------------------------------
`ifdef TE_INPUT_SYNC_EN
    logic [NUM_CH-1:0] en_meta_q;
    logic [NUM_CH-1:0] rx_meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_meta_q <= '0;
            rx_meta_q <= '0;
            en_sync_q <= '0;
            rx_sync_q <= '0;
        end else begin
            en_meta_q <= radioEnableUnsynced;
            rx_meta_q <= radioRxEnUnsynced;
            en_sync_q <= en_meta_q;
            rx_sync_q <= rx_meta_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            en_sync_q <= '0;
            rx_sync_q <= '0;
        end else begin
            en_sync_q <= radioEnableUnsynced;
            rx_sync_q <= radioRxEnUnsynced;
        end
    end
`endif

    assign radioEnableSynced = en_sync_q;
    assign radioRxEnSynced   = rx_sync_q;

    // ------------------------------------------------------------------
    // Per-channel sequencer
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_e           state_q;
            logic [CNT_W-1:0] cnt_q;
            logic             rx_mode_q;
            logic             ena_q;
            logic             rxen_q;
            logic             err_q;
            logic             en;
            logic             rx;

            assign en = en_sync_q[gi];
            assign rx = rx_sync_q[gi];

            // Outputs are registered alongside the state: every branch that
            // lands in ACTIVE or FAULT sets the matching output, everything
            // else leaves the cleared default, so outputs track the state
            // register exactly.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    rx_mode_q <= 1'b0;
                    ena_q     <= 1'b0;
                    rxen_q    <= 1'b0;
                    err_q     <= 1'b0;
                end else begin
                    ena_q  <= 1'b0;
                    rxen_q <= 1'b0;
                    err_q  <= 1'b0;
                    case (state_q)
                        ST_IDLE: begin
                            if (en) begin
                                state_q   <= ST_WAIT_PLL;
                                cnt_q     <= '0;
                                rx_mode_q <= rx;
                            end
                        end
                        ST_WAIT_PLL: begin
                            if (!en) begin
                                state_q <= ST_IDLE;
                            end else if (pllSettled) begin
                                state_q <= ST_SETTLE;
                                cnt_q   <= settle_load;
                            end else if (cnt_q == PLL_LAST) begin
                                state_q <= ST_FAULT;
                                err_q   <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 16'd1;
                            end
                        end
                        ST_SETTLE: begin
                            if (!en) begin
                                state_q <= ST_IDLE;
                            end else if (!pllSettled) begin
                                state_q <= ST_WAIT_PLL;
                                cnt_q   <= '0;
                            end else if (cnt_q == '0) begin
                                state_q <= ST_ACTIVE;
                                ena_q   <= 1'b1;
                                rxen_q  <= rx_mode_q;
                            end else begin
                                cnt_q <= cnt_q - 16'd1;
                            end
                        end
                        ST_ACTIVE: begin
                            if (!en) begin
                                state_q <= ST_IDLE;
                            end else if (!pllSettled) begin
                                state_q <= ST_WAIT_PLL;
                                cnt_q   <= '0;
                            end else if (rx != rx_mode_q) begin
                                // Turnaround: front end must re-settle in the new mode.
                                state_q   <= ST_SETTLE;
                                cnt_q     <= settle_load;
                                rx_mode_q <= rx;
                            end else begin
                                ena_q  <= 1'b1;
                                rxen_q <= rx_mode_q;
                            end
                        end
                        ST_FAULT: begin
                            if (!en) begin
                                state_q <= ST_IDLE;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
            end

            assign radioEnable[gi] = ena_q;
            assign radioRxEn[gi]   = rxen_q;
            assign teError[gi]     = err_q;
        end
    endgenerate

endmodule

// File: tb/tb_te_radio_seq.sv
// ---------------------------------------------------------------------------
// tb_te_radio_seq
//
// Self-checking bench for te_radio_seq. A timeline-based reference model
// (absolute cycle stamps for wait start and settle end) predicts every output
// on every cycle; directed scenarios additionally pin latencies to literal
// edge counts. Inputs change on the falling edge, outputs are compared on the
// falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_te_radio_seq;

    localparam int NUM_CH = 2;
    localparam int TW     = 8;
    localparam int TO     = 16;

`ifdef TE_INPUT_SYNC_EN
    localparam int SYNC_L  = 2;
    localparam int ENA_LAT = 9;
    localparam int DIS_LAT = 3;
    localparam int TO_LAT  = 19;
`else
    localparam int SYNC_L  = 1;
    localparam int ENA_LAT = 8;
    localparam int DIS_LAT = 2;
    localparam int TO_LAT  = 18;
`endif

    localparam int M_OFF = 0, M_WAIT = 1, M_SETTLE = 2, M_ON = 3, M_FAULT = 4;

    logic              clk;
    logic              rst;
    logic              pll;
    logic [TW-1:0]     t_in;
    logic [NUM_CH-1:0] en_in, rx_in;
    logic [NUM_CH-1:0] en_syn, rx_syn, ena, rxen, err;

    te_radio_seq #(
        .NUM_CH(NUM_CH),
        .SIZE_T_ARSTFS(TW),
        .PLL_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pllSettled(pll),
        .tArstFs(t_in),
        .radioEnableUnsynced(en_in),
        .radioRxEnUnsynced(rx_in),
        .radioEnableSynced(en_syn),
        .radioRxEnSynced(rx_syn),
        .radioEnable(ena),
        .radioRxEn(rxen),
        .teError(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int                now;
    int                mode       [NUM_CH];
    int                wait_start [NUM_CH];
    int                settle_end [NUM_CH];
    bit                want_rx    [NUM_CH];
    logic [NUM_CH-1:0] pipe_en    [SYNC_L];
    logic [NUM_CH-1:0] pipe_rx    [SYNC_L];

    task automatic model_step();
        logic [NUM_CH-1:0] e_v, r_v;
        now++;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mode[c] = M_OFF;
                want_rx[c] = 1'b0;
            end
            for (int i = 0; i < SYNC_L; i++) begin
                pipe_en[i] = '0;
                pipe_rx[i] = '0;
            end
            return;
        end
        e_v = pipe_en[SYNC_L-1];
        r_v = pipe_rx[SYNC_L-1];
        for (int c = 0; c < NUM_CH; c++) begin
            if (!e_v[c]) begin
                mode[c] = M_OFF;               // withdrawing the request always wins
            end else begin
                case (mode[c])
                    M_OFF: begin
                        mode[c] = M_WAIT;
                        wait_start[c] = now;
                        want_rx[c] = r_v[c];
                    end
                    M_WAIT: begin
                        if (pll) begin
                            mode[c] = M_SETTLE;
                            settle_end[c] = now + int'(t_in) + 1;
                        end else if (now - wait_start[c] == TO) begin
                            mode[c] = M_FAULT;
                        end
                    end
                    M_SETTLE: begin
                        if (!pll) begin
                            mode[c] = M_WAIT;
                            wait_start[c] = now;
                        end else if (now == settle_end[c]) begin
                            mode[c] = M_ON;
                        end
                    end
                    M_ON: begin
                        if (!pll) begin
                            mode[c] = M_WAIT;
                            wait_start[c] = now;
                        end else if (r_v[c] != want_rx[c]) begin
                            mode[c] = M_SETTLE;
                            settle_end[c] = now + int'(t_in) + 1;
                            want_rx[c] = r_v[c];
                        end
                    end
                    default: ;
                endcase
            end
        end
        for (int i = SYNC_L - 1; i > 0; i--) begin
            pipe_en[i] = pipe_en[i-1];
            pipe_rx[i] = pipe_rx[i-1];
        end
        pipe_en[0] = en_in;
        pipe_rx[0] = rx_in;
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] x_ena, x_rxen, x_err;
        for (int c = 0; c < NUM_CH; c++) begin
            x_ena[c]  = (mode[c] == M_ON);
            x_rxen[c] = (mode[c] == M_ON) && want_rx[c];
            x_err[c]  = (mode[c] == M_FAULT);
        end
        chk("radioEnableSynced", int'(en_syn), int'(pipe_en[SYNC_L-1]));
        chk("radioRxEnSynced",   int'(rx_syn), int'(pipe_rx[SYNC_L-1]));
        chk("radioEnable",       int'(ena),    int'(x_ena));
        chk("radioRxEn",         int'(rxen),   int'(x_rxen));
        chk("teError",           int'(err),    int'(x_err));
    endtask

    // One rising edge, model update, then compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    function automatic bit sel(input int which);
        case (which)
            0:       return ena[0];
            1:       return err[1];
            default: return rxen[0];
        endcase
    endfunction

    // Edges until the selected output reaches target (bounded).
    task automatic count_edges(input int which, input bit target, output int n);
        n = 0;
        while (sel(which) !== target && n < 100) begin
            cycle();
            n++;
        end
    endtask

    int n;
    int idx;

    initial begin
        now = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            mode[c] = M_OFF;
            want_rx[c] = 1'b0;
            wait_start[c] = 0;
            settle_end[c] = 0;
        end
        for (int i = 0; i < SYNC_L; i++) begin
            pipe_en[i] = '0;
            pipe_rx[i] = '0;
        end
        rst = 1'b1; pll = 1'b0; t_in = 8'd4; en_in = '0; rx_in = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle();
        chk("reset_outputs", int'({ena, rxen, err, en_syn, rx_syn}), 0);
        rst = 1'b0;

        // Enable latency: tArstFs=4, PLL locked, RX request on ch0.
        pll = 1'b1; rx_in = 2'b01;
        for (int i = 0; i < 4; i++) cycle();
        en_in = 2'b01;
        for (int k = 1; k <= ENA_LAT; k++) begin
            cycle();
            if (k == ENA_LAT - 1) chk("ena_before_latency", int'(ena[0]), 0);
        end
        chk("ena_at_latency", int'(ena[0]), 1);
        chk("rxen_at_latency", int'(rxen[0]), 1);
        chk("ch1_idle", int'({ena[1], rxen[1], err[1]}), 0);

        // Turnaround RX -> TX: low for tArstFs+1 cycles.
        rx_in = 2'b00;
        count_edges(0, 1'b0, n);
        count_edges(0, 1'b1, n);
        chk("turnaround_low_cycles", n, 5);
        chk("turnaround_rxen", int'(rxen[0]), 0);

        // PLL loss for 3 cycles.
        pll = 1'b0;
        cycle();
        chk("pll_loss_ena", int'(ena[0]), 0);
        cycle(); cycle();
        pll = 1'b1;
        count_edges(0, 1'b1, n);
        chk("pll_return_latency", n, 6);

        // Disable latency.
        en_in = 2'b00;
        count_edges(0, 1'b0, n);
        chk("disable_latency", n, DIS_LAT);

        // PLL timeout on ch1.
        for (int i = 0; i < 4; i++) cycle();
        pll = 1'b0; en_in = 2'b10;
        count_edges(1, 1'b1, n);
        chk("timeout_latency", n, TO_LAT);
        for (int i = 0; i < 5; i++) cycle();
        chk("fault_holds", int'(err[1]), 1);
        en_in = 2'b00;
        count_edges(1, 1'b0, n);
        chk("fault_clear_latency", n, DIS_LAT);

        // Reset with both channels in SETTLE.
        pll = 1'b1; t_in = 8'd7; en_in = 2'b11;
        for (int i = 0; i < SYNC_L + 3; i++) cycle();
        rst = 1'b1;
        cycle();
        chk("reset_mid_settle", int'({ena, rxen, err, en_syn, rx_syn}), 0);
        rst = 1'b0;
        for (int i = 0; i < ENA_LAT - 1; i++) cycle();
        chk("restart_not_yet", int'(ena), 0);

        // Randomised traffic.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 29) == 0) begin
                idx = int'($urandom_range(0, NUM_CH - 1));
                en_in[idx] = ~en_in[idx];
            end
            if ($urandom_range(0, 19) == 0) begin
                idx = int'($urandom_range(0, NUM_CH - 1));
                rx_in[idx] = ~rx_in[idx];
            end
            if ($urandom_range(0, 24) == 0) pll = ~pll;
            if ($urandom_range(0, 9) == 0) t_in = TW'($urandom_range(0, 6));
            rst = ($urandom_range(0, 399) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
